// File: rtl/fb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_ctrl_pkg
// Description : Shared types and constants for the line-buffer controller:
//               write-arbiter state encoding and pipeline latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_ctrl_pkg;

    // Write-port owner: host traffic in IDLE, fill engine in FILL
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // word_req_i -> pix_valid_o (SRAM read cycle + output register)
    localparam int c_rd_latency = 2;
    // host accept -> wr_en_o
    localparam int c_wr_latency = 1;

endpackage : fb_ctrl_pkg
`default_nettype wire

// File: rtl/fb_line_ctrl_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-MAX up counter with restart. clr restarts the count
//               at zero; inc advances from the (possibly restarted) base, so
//               clr and inc together yield 1. Wraps MAX-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int MAX = 48,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] c_last = W'(MAX - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic [W-1:0] w_base;

    // Next count: restart first, then advance with wrap at MAX-1
    always_comb begin
        w_base  = clr ? '0 : value_q;
        value_d = w_base;
        if (inc) begin
            value_d = (w_base == c_last) ? '0 : w_base + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : wrap_counter
`default_nettype wire

// File: rtl/fb_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fb_line_ctrl
// Description : Line-buffer SRAM sequencer for the VGA path. Read side turns
//               display word requests into SRAM addresses and re-times the
//               1-cycle SRAM read into a registered pixel-word stream. Write
//               side shares the single SRAM write port between a host
//               valid/ready writer and a whole-RAM fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_line_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int DW    = 64,
    parameter int WORDS = 48,
    parameter int ADDRW = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    // display read side
    input  logic             line_start_i,
    input  logic             word_req_i,
    output logic [ADDRW-1:0] rd_addr_o,
    input  logic [DW-1:0]    rd_data_i,
    output logic [DW-1:0]    pix_word_o,
    output logic             pix_valid_o,
    // host writer
    input  logic             host_wr_valid_i,
    output logic             host_wr_ready_o,
    input  logic [ADDRW-1:0] host_wr_addr_i,
    input  logic [DW-1:0]    host_wr_data_i,
    // fill engine control
    input  logic             fill_start_i,
    input  logic [DW-1:0]    fill_value_i,
    output logic             fill_busy_o,
    output logic             fill_done_o,
    // SRAM write port
    output logic             wr_en_o,
    output logic [ADDRW-1:0] wr_addr_o,
    output logic [DW-1:0]    wr_data_o,
    output logic             addr_err_o
);

    // One extra bit so a power-of-two depth still compares correctly
    localparam logic [ADDRW:0]   c_words     = (ADDRW + 1)'(WORDS);
    localparam logic [ADDRW-1:0] c_last_addr = ADDRW'(WORDS - 1);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [ADDRW-1:0] rd_ptr;
    logic [ADDRW-1:0] fill_cnt;

    logic             req_d1_q,    req_d1_d;
    logic             pix_valid_q, pix_valid_d;
    logic [DW-1:0]    pix_word_q,  pix_word_d;

    fill_state_e      state_q,      state_d;
    logic [DW-1:0]    fill_value_q, fill_value_d;
    logic             fill_busy_q,  fill_busy_d;
    logic             fill_done_q,  fill_done_d;
    logic             wr_en_q,      wr_en_d;
    logic [ADDRW-1:0] wr_addr_q,    wr_addr_d;
    logic [DW-1:0]    wr_data_q,    wr_data_d;
    logic             addr_err_q,   addr_err_d;

    logic             w_in_fill;
    logic             w_fill_accept;
    logic             w_host_accept;
    logic             w_addr_ok;
    logic             w_fill_last;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    // line_start_i restarts the pointer; a request in the same cycle reads
    // word 0 and leaves the pointer at 1.
    wrap_counter #(
        .MAX (WORDS),
        .W   (ADDRW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (line_start_i),
        .inc   (word_req_i),
        .value (rd_ptr)
    );

    assign rd_addr_o = line_start_i ? '0 : rd_ptr;

    // Delay the request by the SRAM read cycle, then capture the word
    always_comb begin
        req_d1_d    = word_req_i;
        pix_valid_d = req_d1_q;
        pix_word_d  = req_d1_q ? rd_data_i : pix_word_q;
    end

    // Read pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d1_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_word_q  <= '0;
        end else begin
            req_d1_q    <= req_d1_d;
            pix_valid_q <= pix_valid_d;
            pix_word_q  <= pix_word_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign pix_word_o  = pix_word_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign w_in_fill     = (state_q == ST_FILL);
    assign w_fill_accept = (state_q == ST_IDLE) & fill_start_i;
    // A fill start wins over a simultaneous host request; ready stays low
    // through the whole fill so host and fill writes never collide.
    assign host_wr_ready_o = (state_q == ST_IDLE) & ~fill_start_i & ~rst;
    assign w_host_accept   = host_wr_valid_i & host_wr_ready_o;
    assign w_addr_ok       = ({1'b0, host_wr_addr_i} < c_words);
    assign w_fill_last     = w_in_fill & (fill_cnt == c_last_addr);

    // Fill address counter: restarted on accepted start, stepped in FILL
    wrap_counter #(
        .MAX (WORDS),
        .W   (ADDRW)
    ) u_fill_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_fill_accept),
        .inc   (w_in_fill),
        .value (fill_cnt)
    );

    // Arbiter next state and registered write-port commands
    always_comb begin
        state_d      = state_q;
        fill_value_d = fill_value_q;
        fill_busy_d  = w_fill_accept | w_in_fill;
        fill_done_d  = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        addr_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_fill_accept) begin
                    state_d      = ST_FILL;
                    fill_value_d = fill_value_i;
                end else if (w_host_accept) begin
                    if (w_addr_ok) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = host_wr_addr_i;
                        wr_data_d = host_wr_data_i;
                    end else begin
                        // out-of-range: complete the handshake, drop data
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = fill_cnt;
                wr_data_d = fill_value_q;
                if (w_fill_last) begin
                    state_d     = ST_IDLE;
                    fill_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state and registered outputs; reset aborts any fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_value_q <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_value_q <= fill_value_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign fill_busy_o = fill_busy_q;
    assign fill_done_o = fill_done_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign addr_err_o  = addr_err_q;

endmodule : fb_line_ctrl
`default_nettype wire

// File: tb/tb_fb_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_line_ctrl
// Description : Self-checking bench for fb_line_ctrl with a behavioural
//               dual-port SRAM (registered read, old data on read-during-
//               write) and a word-level reference image of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_line_ctrl;

    localparam int DW    = 64;
    localparam int WORDS = 48;
    localparam int AW    = $clog2(WORDS);

    logic          clk;
    logic          rst;
    logic          line_start, word_req, host_valid, fill_start;
    logic [AW-1:0] rd_addr, host_addr, wr_addr;
    logic [DW-1:0] rd_data, pix_word, host_data, fill_value, wr_data;
    logic          pix_valid, host_ready, fill_busy, fill_done, wr_en, addr_err;

    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:WORDS-1];
    logic [AW-1:0] last_wr_addr;
    int            errors = 0;
    int            checks = 0;

    fb_line_ctrl #(
        .DW    (DW),
        .WORDS (WORDS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .line_start_i    (line_start),
        .word_req_i      (word_req),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data),
        .pix_word_o      (pix_word),
        .pix_valid_o     (pix_valid),
        .host_wr_valid_i (host_valid),
        .host_wr_ready_o (host_ready),
        .host_wr_addr_i  (host_addr),
        .host_wr_data_i  (host_data),
        .fill_start_i    (fill_start),
        .fill_value_i    (fill_value),
        .fill_busy_o     (fill_busy),
        .fill_done_o     (fill_done),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .addr_err_o      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read returns pre-write contents
    always @(posedge clk) begin
        if (wr_en) sram[wr_addr] <= wr_data;
        rd_data <= sram[rd_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        host_valid = 1'b1;
        host_addr  = '0;
        @(negedge clk);
        checks++; if ({pix_valid, pix_word, wr_en, wr_addr, wr_data, fill_busy, fill_done, addr_err, host_ready, rd_addr} !== '0) begin errors++; $display("FAIL reset_outputs: got pv=%0b pw=%h we=%0b wa=%0d wd=%h busy=%0b done=%0b err=%0b rdy=%0b ra=%0d expected all zero", pix_valid, pix_word, wr_en, wr_addr, wr_data, fill_busy, fill_done, addr_err, host_ready, rd_addr); end
        next_cycle();
        rst        = 1'b0;
        host_valid = 1'b0;
        @(negedge clk);
        checks++; if ({host_ready, fill_busy, wr_en} !== 3'b100) begin errors++; $display("FAIL reset_release: got rdy=%0b busy=%0b we=%0b expected 1 0 0", host_ready, fill_busy, wr_en); end
        next_cycle();
    endtask

    task automatic test_readback(input string name);
        for (int c = 0; c <= WORDS + 2; c++) begin
            line_start = (c == 0);
            word_req   = (c < WORDS);
            @(negedge clk);
            if (c >= 2 && c < WORDS + 2) begin
                checks++; if ({pix_valid, pix_word} !== {1'b1, ref_mem[c-2]}) begin errors++; $display("FAIL %s_rd%0d: got valid=%0b word=%h expected valid=1 word=%h", name, c - 2, pix_valid, pix_word, ref_mem[c-2]); end
            end else if (c == WORDS + 2) begin
                checks++; if ({pix_valid, pix_word} !== {1'b0, ref_mem[WORDS-1]}) begin errors++; $display("FAIL %s_hold: got valid=%0b word=%h expected valid=0 word=%h", name, pix_valid, pix_word, ref_mem[WORDS-1]); end
            end
            next_cycle();
        end
        line_start = 1'b0;
        word_req   = 1'b0;
    endtask

    task automatic test_host_writes_reads();
        logic [DW-1:0] exp_w;
        for (int c = 0; c <= WORDS + 1; c++) begin
            host_valid = (c < WORDS);
            host_addr  = AW'(c);
            host_data  = 64'hA5A5_0000_0000_0000 | 64'(c);
            @(negedge clk);
            if (c < WORDS) begin
                checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL hw_ready%0d: got %0b expected 1", c, host_ready); end
            end
            if (c >= 1 && c <= WORDS) begin
                exp_w = 64'hA5A5_0000_0000_0000 | 64'(c - 1);
                checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(c - 1), exp_w}) begin errors++; $display("FAIL hw_write%0d: got we=%0b wa=%0d wd=%h expected we=1 wa=%0d wd=%h", c - 1, wr_en, wr_addr, wr_data, c - 1, exp_w); end
            end else if (c == WORDS + 1) begin
                checks++; if ({wr_en, wr_addr} !== {1'b0, AW'(WORDS - 1)}) begin errors++; $display("FAIL hw_idle: got we=%0b wa=%0d expected we=0 wa=%0d", wr_en, wr_addr, WORDS - 1); end
            end
            next_cycle();
        end
        host_valid = 1'b0;
        for (int k = 0; k < WORDS; k++) ref_mem[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        last_wr_addr = AW'(WORDS - 1);
        // 49 requests from line start: addresses 0..47 then wrap to 0
        for (int c = 0; c <= WORDS + 3; c++) begin
            line_start = (c == 0);
            word_req   = (c <= WORDS);
            @(negedge clk);
            if (c <= WORDS) begin
                checks++; if (rd_addr !== AW'(c % WORDS)) begin errors++; $display("FAIL rd_addr%0d: got %0d expected %0d", c, rd_addr, c % WORDS); end
            end
            if (c >= 2 && c <= WORDS + 2) begin
                checks++; if ({pix_valid, pix_word} !== {1'b1, ref_mem[(c-2) % WORDS]}) begin errors++; $display("FAIL seq_rd%0d: got valid=%0b word=%h expected valid=1 word=%h", c - 2, pix_valid, pix_word, ref_mem[(c-2) % WORDS]); end
            end else begin
                checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL seq_novalid%0d: got %0b expected 0", c, pix_valid); end
            end
            next_cycle();
        end
        word_req = 1'b0;
    endtask

    // Fill started at c=0; host request held from host_from until the one
    // cycle it is expected to be accepted (c = WORDS+1).
    task automatic test_fill_host(input logic [DW-1:0] fval, input int host_from,
                                  input logic [AW-1:0] haddr, input logic [DW-1:0] hdata,
                                  input string name);
        logic [2:0]          exp_ctl;
        logic [AW+DW:0]      exp_wr;
        for (int c = 0; c <= WORDS + 4; c++) begin
            fill_start = (c == 0) || (c == 20);
            fill_value = (c == 0) ? fval : ~fval;
            host_valid = (c >= host_from) && (c <= WORDS + 1);
            host_addr  = haddr;
            host_data  = hdata;
            @(negedge clk);
            exp_ctl = {c >= WORDS + 1, c >= 1 && c <= WORDS + 1, c == WORDS + 1};
            checks++; if ({host_ready, fill_busy, fill_done} !== exp_ctl) begin errors++; $display("FAIL %s_ctl%0d: got rdy/busy/done=%b expected %b", name, c, {host_ready, fill_busy, fill_done}, exp_ctl); end
            if (c >= 2 && c <= WORDS + 1) exp_wr = {1'b1, AW'(c - 2), fval};
            else if (c == WORDS + 2)      exp_wr = {1'b1, haddr, hdata};
            else                          exp_wr = {1'b0, wr_addr, wr_data};
            checks++; if ({wr_en, wr_addr, wr_data, addr_err} !== {exp_wr, 1'b0}) begin errors++; $display("FAIL %s_wr%0d: got we=%0b wa=%0d wd=%h err=%0b expected we=%0b wa=%0d wd=%h err=0", name, c, wr_en, wr_addr, wr_data, addr_err, exp_wr[AW+DW], exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]); end
            next_cycle();
        end
        fill_start = 1'b0;
        host_valid = 1'b0;
        for (int k = 0; k < WORDS; k++) ref_mem[k] = fval;
        ref_mem[haddr] = hdata;
        last_wr_addr   = haddr;
        test_readback(name);
    endtask

    task automatic test_bad_addr();
        for (int k = 0; k < 2; k++) begin
            host_valid = 1'b1;
            host_addr  = (k == 0) ? AW'(WORDS) : AW'($urandom_range(WORDS + 1, (1 << AW) - 1));
            host_data  = {$urandom, $urandom};
            @(negedge clk);
            checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL bad_ready%0d: got %0b expected 1", k, host_ready); end
            next_cycle();
            host_valid = 1'b0;
            @(negedge clk);
            checks++; if ({wr_en, addr_err, wr_addr} !== {1'b0, 1'b1, last_wr_addr}) begin errors++; $display("FAIL bad_drop%0d: got we=%0b err=%0b wa=%0d expected we=0 err=1 wa=%0d", k, wr_en, addr_err, wr_addr, last_wr_addr); end
            next_cycle();
            @(negedge clk);
            checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL bad_pulse%0d: got %0b expected 0", k, addr_err); end
            next_cycle();
        end
        test_readback("bad_addr");
    endtask

    // off=0: write to word 3 lands in the cycle word 3 is read (old data);
    // off=1: it lands one cycle earlier (new data).
    task automatic test_rdw();
        logic [DW-1:0] old_w, new_w, exp_w;
        for (int off = 0; off < 2; off++) begin
            old_w = ref_mem[3];
            new_w = old_w ^ {32'h1, $urandom};
            exp_w = (off == 0) ? old_w : new_w;
            for (int c = 0; c <= 6; c++) begin
                line_start = (c == 0);
                word_req   = (c <= 3);
                host_valid = (c == 2 - off);
                host_addr  = AW'(3);
                host_data  = new_w;
                @(negedge clk);
                if (c == 3 - off) begin
                    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(3), new_w}) begin errors++; $display("FAIL rdw_wr%0d: got we=%0b wa=%0d wd=%h expected we=1 wa=3 wd=%h", off, wr_en, wr_addr, wr_data, new_w); end
                end
                if (c == 3) begin
                    checks++; if (rd_addr !== AW'(3)) begin errors++; $display("FAIL rdw_addr%0d: got %0d expected 3", off, rd_addr); end
                end
                if (c == 5) begin
                    checks++; if ({pix_valid, pix_word} !== {1'b1, exp_w}) begin errors++; $display("FAIL rdw_data%0d: got valid=%0b word=%h expected valid=1 word=%h", off, pix_valid, pix_word, exp_w); end
                end
                next_cycle();
            end
            ref_mem[3]   = new_w;
            last_wr_addr = AW'(3);
        end
        line_start = 1'b0;
        word_req   = 1'b0;
        host_valid = 1'b0;
    endtask

    task automatic test_random_traffic();
        int            ptr = 0;
        int            ea;
        logic          cur_v, d1_v = 1'b0, d2_v = 1'b0, have_w = 1'b0;
        logic [DW-1:0] cur_w, d1_w = '0, d2_w = '0, last_w = '0;
        logic          p_acc = 1'b0, p_ok = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_data = '0;
        for (int t = 0; t < 400; t++) begin
            line_start = ($urandom_range(0, 15) == 0);
            word_req   = ($urandom_range(0, 2) != 0);
            host_valid = $urandom_range(0, 1) == 1;
            host_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(WORDS, (1 << AW) - 1)) : AW'($urandom_range(0, WORDS - 1));
            host_data  = {$urandom, $urandom};
            ea    = line_start ? 0 : ptr;
            cur_v = word_req;
            cur_w = ref_mem[ea];
            if (word_req) ptr = (ea + 1) % WORDS;
            else if (line_start) ptr = 0;
            @(negedge clk);
            checks++; if ({rd_addr, host_ready} !== {AW'(ea), 1'b1}) begin errors++; $display("FAIL rnd_addr%0d: got ra=%0d rdy=%0b expected ra=%0d rdy=1", t, rd_addr, host_ready, ea); end
            if (p_acc && p_ok) begin
                checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, p_addr, p_data}) begin errors++; $display("FAIL rnd_wr%0d: got we=%0b wa=%0d wd=%h expected we=1 wa=%0d wd=%h", t, wr_en, wr_addr, wr_data, p_addr, p_data); end
                ref_mem[p_addr] = p_data;
                last_wr_addr    = p_addr;
            end else begin
                checks++; if ({wr_en, wr_addr} !== {1'b0, last_wr_addr}) begin errors++; $display("FAIL rnd_nowr%0d: got we=%0b wa=%0d expected we=0 wa=%0d", t, wr_en, wr_addr, last_wr_addr); end
            end
            checks++; if (addr_err !== (p_acc && !p_ok)) begin errors++; $display("FAIL rnd_err%0d: got %0b expected %0b", t, addr_err, p_acc && !p_ok); end
            checks++; if (pix_valid !== d2_v) begin errors++; $display("FAIL rnd_pv%0d: got %0b expected %0b", t, pix_valid, d2_v); end
            if (d2_v) begin
                checks++; if (pix_word !== d2_w) begin errors++; $display("FAIL rnd_pw%0d: got %h expected %h", t, pix_word, d2_w); end
                last_w = d2_w;
                have_w = 1'b1;
            end else if (have_w) begin
                checks++; if (pix_word !== last_w) begin errors++; $display("FAIL rnd_hold%0d: got %h expected %h", t, pix_word, last_w); end
            end
            d2_v = d1_v; d2_w = d1_w;
            d1_v = cur_v; d1_w = cur_w;
            p_acc  = host_valid;
            p_ok   = (int'(host_addr) < WORDS);
            p_addr = host_addr;
            p_data = host_data;
            next_cycle();
        end
        line_start = 1'b0;
        word_req   = 1'b0;
        host_valid = 1'b0;
        if (p_acc && p_ok) begin
            ref_mem[p_addr] = p_data;
            last_wr_addr    = p_addr;
        end
        repeat (3) next_cycle();
    endtask

    // Reset asserted in fill cycle 10: words 0..7 were written in cycles
    // 2..9; the write of word 8 is cut off by the asynchronous reset.
    task automatic test_reset_midfill();
        logic [DW-1:0] fval;
        fval = {$urandom, $urandom};
        for (int c = 0; c <= 15; c++) begin
            fill_start = (c == 0);
            fill_value = fval;
            if (c == 10) begin rst = 1'b1; host_valid = 1'b1; host_addr = AW'(1); end
            if (c == 12) begin rst = 1'b0; host_valid = 1'b0; end
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                checks++; if ({wr_en, wr_addr, wr_data, fill_busy} !== {1'b1, AW'(c - 2), fval, 1'b1}) begin errors++; $display("FAIL mf_wr%0d: got we=%0b wa=%0d wd=%h busy=%0b expected we=1 wa=%0d wd=%h busy=1", c, wr_en, wr_addr, wr_data, fill_busy, c - 2, fval); end
            end else if (c == 10 || c == 11) begin
                checks++; if ({pix_valid, pix_word, wr_en, wr_addr, wr_data, fill_busy, fill_done, addr_err, host_ready, rd_addr} !== '0) begin errors++; $display("FAIL mf_reset%0d: got pv=%0b pw=%h we=%0b wa=%0d wd=%h busy=%0b done=%0b err=%0b rdy=%0b ra=%0d expected all zero", c, pix_valid, pix_word, wr_en, wr_addr, wr_data, fill_busy, fill_done, addr_err, host_ready, rd_addr); end
            end else if (c >= 12) begin
                checks++; if ({host_ready, fill_busy, fill_done, wr_en} !== 4'b1000) begin errors++; $display("FAIL mf_after%0d: got rdy/busy/done/we=%b expected 1000", c, {host_ready, fill_busy, fill_done, wr_en}); end
            end
            next_cycle();
        end
        fill_start = 1'b0;
        for (int k = 0; k < 8; k++) ref_mem[k] = fval;
        last_wr_addr = '0;
        test_readback("midfill");
    endtask

    initial begin
        rst        = 1'b1;
        line_start = 1'b0;
        word_req   = 1'b0;
        host_valid = 1'b0;
        host_addr  = '0;
        host_data  = '0;
        fill_start = 1'b0;
        fill_value = '0;
        last_wr_addr = '0;
        repeat (2) next_cycle();
        test_reset();
        test_host_writes_reads();
        test_fill_host(64'hDEAD_BEEF_DEAD_BEEF, 1, AW'(9), {$urandom, $urandom}, "fill");
        test_fill_host({$urandom, $urandom}, 0, AW'(5), 64'h1234, "contend");
        test_bad_addr();
        test_rdw();
        test_random_traffic();
        test_readback("random");
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule : tb_fb_line_ctrl
`default_nettype wire
